// File: rtl/test_sequencer.sv
// Run controller: clears stats, enables generators for the requested ms, drains, then reports.
// Optional run abort is compiled in with `define TEST_SEQ_ABORT_EN (adds the abort input).
module test_sequencer #(
    parameter int NUM_PORTS     = 4,
    parameter int CYCLES_PER_MS = 125000,
    parameter int DRAIN_MS      = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [12:0]          cfg_duration,
    input  logic                 cfg_start,
    input  logic [NUM_PORTS-1:0] port_enable,
`ifdef TEST_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy,
    output logic [12:0]          actual_duration,
    output logic                 stats_clear,
    output logic [NUM_PORTS-1:0] gen_enable,
    output logic [NUM_PORTS-1:0] chk_enable,
    output logic                 done
);

    localparam int CYC_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam int MS_W  = $clog2(DRAIN_MS + 1);
    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(CYCLES_PER_MS - 1);
    localparam logic [MS_W-1:0]  DRAIN_LAST = MS_W'(DRAIN_MS - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t               state;
    logic [12:0]          dur_q;
    logic [12:0]          elapsed;
    logic [NUM_PORTS-1:0] pen_q;
    logic [CYC_W-1:0]     cyc_cnt;
    logic [MS_W-1:0]      ms_cnt;
    logic                 ms_tick;
    logic [12:0]          elapsed_inc;
    logic                 abort_req;

    assign ms_tick     = (cyc_cnt == CYC_LAST);
    assign elapsed_inc = elapsed + 13'd1;

`ifdef TEST_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            dur_q           <= '0;
            pen_q           <= '0;
            elapsed         <= '0;
            cyc_cnt         <= '0;
            ms_cnt          <= '0;
            busy            <= 1'b0;
            actual_duration <= '0;
            stats_clear     <= 1'b0;
            gen_enable      <= '0;
            chk_enable      <= '0;
            done            <= 1'b0;
        end else begin
            stats_clear <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        dur_q       <= cfg_duration;
                        pen_q       <= port_enable;
                        busy        <= 1'b1;
                        stats_clear <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    cyc_cnt    <= '0;
                    ms_cnt     <= '0;
                    elapsed    <= '0;
                    chk_enable <= pen_q;
                    if (dur_q == 13'd0) begin
                        state <= DRAIN;
                    end else begin
                        gen_enable <= pen_q;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (ms_tick) begin
                        cyc_cnt <= '0;
                        elapsed <= elapsed_inc;
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                    // An abort on a wrap cycle still credits the ms that just completed.
                    if ((ms_tick && elapsed_inc == dur_q) || abort_req) begin
                        cyc_cnt    <= '0;
                        gen_enable <= '0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ms_tick) begin
                        cyc_cnt <= '0;
                        if (ms_cnt == DRAIN_LAST) begin
                            chk_enable      <= '0;
                            done            <= 1'b1;
                            actual_duration <= elapsed;
                            state           <= DONE;
                        end else begin
                            ms_cnt <= ms_cnt + MS_W'(1);
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: vector table, random runs vs. arithmetic model, corner sequences.
module tb_test_sequencer;

    localparam int NP   = 4;
    localparam int CPM  = 10;
    localparam int DMS  = 3;
    localparam int CPM2 = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic [12:0] cfgDuration = '0;
    logic        cfgStart    = 1'b0;
    logic [3:0]  portEnable  = '0;
    logic        busy;
    logic [12:0] actualDuration;
    logic        statsClear;
    logic [3:0]  genEnable;
    logic [3:0]  chkEnable;
    logic        done;

    logic [12:0] cfgDuration2 = '0;
    logic        cfgStart2    = 1'b0;
    logic [3:0]  portEnable2  = '0;
    logic        busy2;
    logic [12:0] actualDuration2;
    logic        statsClear2;
    logic [3:0]  genEnable2;
    logic [3:0]  chkEnable2;
    logic        done2;

`ifdef TEST_SEQ_ABORT_EN
    logic        abortIn  = 1'b0;
    logic        abortIn2 = 1'b0;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        int         dur;
        logic [3:0] pen;
        int         expBusy;
        int         expGen;
        int         expActual;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    test_sequencer #(.NUM_PORTS(NP), .CYCLES_PER_MS(CPM), .DRAIN_MS(DMS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_duration(cfgDuration),
        .cfg_start(cfgStart),
        .port_enable(portEnable),
`ifdef TEST_SEQ_ABORT_EN
        .abort(abortIn),
`endif
        .busy(busy),
        .actual_duration(actualDuration),
        .stats_clear(statsClear),
        .gen_enable(genEnable),
        .chk_enable(chkEnable),
        .done(done)
    );

    test_sequencer #(.NUM_PORTS(NP), .CYCLES_PER_MS(CPM2), .DRAIN_MS(DMS)) dutMax (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_duration(cfgDuration2),
        .cfg_start(cfgStart2),
        .port_enable(portEnable2),
`ifdef TEST_SEQ_ABORT_EN
        .abort(abortIn2),
`endif
        .busy(busy2),
        .actual_duration(actualDuration2),
        .stats_clear(statsClear2),
        .gen_enable(genEnable2),
        .chk_enable(chkEnable2),
        .done(done2)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Called at a negedge; runs one whole test and checks its observed waveform shape.
    task automatic applyStimulus(input string tag, input int dur, input logic [3:0] pen,
                                 input int midStartIdx, input int abortIdx,
                                 input int expBusy, input int expGen, input int expActual);
        int idx      = 0;
        int busyCnt  = 0;
        int genCnt   = 0;
        int chkCnt   = 0;
        int clrCnt   = 0;
        int doneCnt  = 0;
        int genFirst = -1;
        int chkLast  = -1;
        int doneIdx  = -1;
        int badVal   = 0;
        cfgDuration = 13'(dur);
        portEnable  = pen;
        cfgStart    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfgStart    = 1'b0;
        cfgDuration = 13'd9;
        portEnable  = ~pen;
        while (busy && idx < 20000) begin
            busyCnt++;
            if (statsClear) clrCnt++;
            if (done) begin
                doneCnt++;
                doneIdx = idx;
            end
            if (genEnable != 4'd0) begin
                genCnt++;
                if (genFirst < 0) genFirst = idx;
                if (genEnable != pen) badVal++;
            end
            if (chkEnable != 4'd0) begin
                chkCnt++;
                chkLast = idx;
                if (chkEnable != pen) badVal++;
            end
            cfgStart = (idx == midStartIdx);
`ifdef TEST_SEQ_ABORT_EN
            abortIn = (idx == abortIdx);
`else
            if (abortIdx >= 0 && idx == 0) $display("[TB] abort index ignored in this build");
`endif
            @(negedge clk);
            idx++;
        end
        cfgStart = 1'b0;
`ifdef TEST_SEQ_ABORT_EN
        abortIn = 1'b0;
`endif
        checkOutput({tag, ".busyCycles"}, busyCnt, expBusy);
        checkOutput({tag, ".genCycles"}, genCnt, expGen);
        checkOutput({tag, ".chkCycles"}, chkCnt, expBusy - 2);
        checkOutput({tag, ".genFirst"}, genFirst, (expGen > 0) ? 1 : -1);
        checkOutput({tag, ".clearPulses"}, clrCnt, 1);
        checkOutput({tag, ".donePulses"}, doneCnt, 1);
        checkOutput({tag, ".doneIdx"}, doneIdx, expBusy - 1);
        checkOutput({tag, ".chkLast"}, chkLast, expBusy - 2);
        checkOutput({tag, ".portValue"}, badVal, 0);
        checkOutput({tag, ".actual"}, int'(actualDuration), expActual);
    endtask

    initial begin
        int d;
        int k;
        int gen;
        int act;
        int abIdx;
        int cnt;
        int bcnt;
        int dcnt;
        logic [3:0] p;

        vecs[0] = '{5, 4'b1011, 82, 50, 5};
        vecs[1] = '{0, 4'b0110, 32, 0, 0};
        vecs[2] = '{1, 4'b1111, 42, 10, 1};
        vecs[3] = '{2, 4'b0001, 52, 20, 2};

        repeat (3) @(negedge clk);
        checkOutput("reset.busy", int'(busy), 0);
        checkOutput("reset.actual", int'(actualDuration), 0);
        checkOutput("reset.statsClear", int'(statsClear), 0);
        checkOutput("reset.gen", int'(genEnable), 0);
        checkOutput("reset.chk", int'(chkEnable), 0);
        checkOutput("reset.done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Tests run back to back, so each start lands on the first cycle busy is low.
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].dur, vecs[i].pen, -1, -1,
                          vecs[i].expBusy, vecs[i].expGen, vecs[i].expActual);
        end

        for (int i = 0; i < 6; i++) begin
            d     = $urandom_range(0, 12);
            p     = 4'($urandom_range(1, 15));
            gen   = d * CPM;
            act   = d;
            abIdx = -1;
`ifdef TEST_SEQ_ABORT_EN
            if (d > 0 && $urandom_range(0, 1) == 1) begin
                k     = $urandom_range(0, d * CPM - 1);
                abIdx = 1 + k;
                gen   = k + 1;
                act   = (k + 1) / CPM;
            end
`endif
            applyStimulus($sformatf("rand%0d", i), d, p, -1, abIdx, 2 + gen + DMS * CPM, gen, act);
        end

        applyStimulus("startWhileBusy", 5, 4'b1011, 20, -1, 82, 50, 5);
        applyStimulus("startOnDone", 4, 4'b1100, 71, -1, 72, 40, 4);
        @(negedge clk);
        checkOutput("startOnDone.stillIdle", int'(busy), 0);

        cfgDuration = 13'd5;
        portEnable  = 4'b1011;
        cfgStart    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfgStart = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("asyncReset.genBefore", int'(genEnable), 11);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncReset.busy", int'(busy), 0);
        checkOutput("asyncReset.gen", int'(genEnable), 0);
        checkOutput("asyncReset.chk", int'(chkEnable), 0);
        checkOutput("asyncReset.actual", int'(actualDuration), 0);
        @(negedge clk);
        checkOutput("asyncReset.done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus("afterReset", 3, 4'b0111, -1, -1, 62, 30, 3);

`ifdef TEST_SEQ_ABORT_EN
        applyStimulus("abort", 8, 4'b1011, -1, 38, 70, 38, 3);
        applyStimulus("abortAtExpiry", 2, 4'b0011, -1, 20, 52, 20, 2);
`endif

        cfgDuration2 = 13'd8191;
        portEnable2  = 4'b0101;
        cfgStart2    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfgStart2 = 1'b0;
        cnt  = 0;
        bcnt = 0;
        dcnt = 0;
        while (busy2 && bcnt < 20000) begin
            bcnt++;
            if (genEnable2 == 4'b0101) cnt++;
            if (done2) dcnt++;
            @(negedge clk);
        end
        checkOutput("maxDur.genCycles", cnt, 8191 * CPM2);
        checkOutput("maxDur.busyCycles", bcnt, 2 + (8191 + DMS) * CPM2);
        checkOutput("maxDur.donePulses", dcnt, 1);
        checkOutput("maxDur.actual", int'(actualDuration2), 8191);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
